// File: rtl/pf_ram_banked.sv
// Banked playfield RAM: CPU port A (one byte lane per access), video port B
// (all lanes in parallel), and a clear sequencer that zeroes every location.

module pf_ram_banked_lane #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int B_BYPASS = 0
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] q_a,
    output logic [DW-1:0] q_b
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign q_a = mem[raddr_a];

    // With bypass on, a same-cycle write to the address port B is reading
    // shows up in this lane immediately instead of the stored value.
    always_comb begin
        q_b = mem[raddr_b];
        if (B_BYPASS != 0 && we && waddr == raddr_b) q_b = wdata;
    end
endmodule

module pf_ram_banked #(
    parameter int NBANKS         = 4,
    parameter int AW             = 8,
    parameter int DW             = 8,
    parameter int CLEAR_ON_RESET = 1,
    parameter int B_BYPASS       = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [AW-1:0]        addr_a,
    input  logic [DW-1:0]        din_a,
    output logic [DW-1:0]        dout_a,
    input  logic [NBANKS-1:0]    ce_a_n,
    input  logic [NBANKS-1:0]    we_a_n,
    input  logic [AW-1:0]        addr_b,
    input  logic                 ce_b_n,
    output logic [NBANKS*DW-1:0] dout_b,
    input  logic                 clr_req,
    output logic                 busy
);
    localparam int SW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                     state;
    logic [AW-1:0]              clr_cnt;
    logic [SW-1:0]              wsel, rsel;
    logic                       wr_a, rd_a;
    logic [NBANKS-1:0][DW-1:0]  q_a, q_b;
    logic [AW-1:0]              waddr;
    logic [DW-1:0]              wdata;

    assign busy  = (state == CLEAR);
    assign wr_a  = ~&we_a_n;
    assign rd_a  = (&we_a_n) & ~&ce_a_n;
    assign waddr = busy ? clr_cnt : addr_a;
    assign wdata = busy ? '0 : din_a;

    // Highest index with an active-low enable wins.
    always_comb begin
        wsel = '0;
        rsel = '0;
        for (int i = 0; i < NBANKS; i++) begin
            if (!we_a_n[i]) wsel = SW'(i);
            if (!ce_a_n[i]) rsel = SW'(i);
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_lane
        logic lane_we;
        assign lane_we = busy | (wr_a && wsel == SW'(b));

        pf_ram_banked_lane #(.AW(AW), .DW(DW), .B_BYPASS(B_BYPASS)) u_lane (
            .clk     (clk),
            .we      (lane_we),
            .waddr   (waddr),
            .wdata   (wdata),
            .raddr_a (addr_a),
            .raddr_b (addr_b),
            .q_a     (q_a[b]),
            .q_b     (q_b[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
            dout_a  <= '0;
            dout_b  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_a)    dout_a <= q_a[rsel];
                    if (!ce_b_n) dout_b <= q_b;
                    if (clr_req) state  <= CLEAR;
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pf_ram_banked.sv
// Directed bench for pf_ram_banked; two instances share stimulus, one per
// port-B bypass mode.
`timescale 1ns/1ps
module tb_pf_ram_banked;
    logic        clk = 0;
    logic        reset_n;
    logic [7:0]  addr_a, din_a, addr_b;
    logic [3:0]  ce_a_n, we_a_n;
    logic        ce_b_n, clr_req;
    logic [7:0]  dout_a0, dout_a1;
    logic [31:0] dout_b0, dout_b1;
    logic        busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pf_ram_banked #(.NBANKS(4), .AW(8), .DW(8), .CLEAR_ON_RESET(1), .B_BYPASS(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0),
        .ce_a_n(ce_a_n), .we_a_n(we_a_n), .addr_b(addr_b), .ce_b_n(ce_b_n),
        .dout_b(dout_b0), .clr_req(clr_req), .busy(busy0));

    pf_ram_banked #(.NBANKS(4), .AW(8), .DW(8), .CLEAR_ON_RESET(1), .B_BYPASS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1),
        .ce_a_n(ce_a_n), .we_a_n(we_a_n), .addr_b(addr_b), .ce_b_n(ce_b_n),
        .dout_b(dout_b1), .clr_req(clr_req), .busy(busy1));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ce_a_n  = '1;
        we_a_n  = '1;
        ce_b_n  = 1'b1;
        clr_req = 1'b0;
    endtask

    task automatic read_b(input logic [7:0] a);
        addr_b = a;
        ce_b_n = 1'b0;
        tick();
        ce_b_n = 1'b1;
    endtask

    task automatic count_busy(input string name);
        int cnt = 0;
        while (busy0 && cnt < 400) begin
            cnt++;
            tick();
        end
        n_checks++;
        if (cnt !== 256) begin
            n_fail++;
            $display("FAIL %s: busy cycles got %0d expected 256", name, cnt);
        end
        n_checks++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: dut1 busy got %b expected 0", name, busy1);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (busy0 !== 1'b1 || dout_a0 !== 8'h00 || dout_b0 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b dout_a=%h dout_b=%h expected 1 00 00000000",
                     busy0, dout_a0, dout_b0);
        end
        reset_n = 1'b1;
        count_busy("reset_clear_len");
        foreach (addr_tab[i]) begin
            read_b(addr_tab[i]);
            n_checks++;
            if (dout_b0 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read_b[%h]: got %h expected 00000000", addr_tab[i], dout_b0);
            end
        end
    endtask
    logic [7:0] addr_tab [3] = '{8'h00, 8'h7F, 8'hFF};

    task automatic test_write_bank2();
        addr_a = 8'h10; din_a = 8'hA5; we_a_n = 4'b1011;
        tick();
        we_a_n = '1;
        read_b(8'h10);
        n_checks++;
        if (dout_b0 !== 32'h00A50000 || dout_b1 !== 32'h00A50000) begin
            n_fail++;
            $display("FAIL write_bank2: got %h/%h expected 00a50000", dout_b0, dout_b1);
        end
    endtask

    task automatic test_priority();
        addr_a = 8'h20; din_a = 8'h3C; we_a_n = 4'b0110;
        tick();
        we_a_n = '1;
        ce_a_n = 4'b1110;
        tick();
        n_checks++;
        if (dout_a0 !== 8'h00) begin
            n_fail++;
            $display("FAIL prio_read_bank0: got %h expected 00", dout_a0);
        end
        ce_a_n = 4'b0111;
        tick();
        n_checks++;
        if (dout_a0 !== 8'h3C) begin
            n_fail++;
            $display("FAIL prio_read_bank3: got %h expected 3c", dout_a0);
        end
        ce_a_n = '1; addr_a = 8'h10;
        tick();
        n_checks++;
        if (dout_a0 !== 8'h3C) begin
            n_fail++;
            $display("FAIL dout_a_hold: got %h expected 3c", dout_a0);
        end
        read_b(8'h20);
        n_checks++;
        if (dout_b0 !== 32'h3C000000) begin
            n_fail++;
            $display("FAIL prio_one_bank: got %h expected 3c000000", dout_b0);
        end
    endtask

    task automatic test_bypass();
        addr_a = 8'h40; din_a = 8'h11; we_a_n = 4'b1110;
        tick();
        din_a = 8'h55; addr_b = 8'h40; ce_b_n = 1'b0;
        tick();
        we_a_n = '1;
        n_checks++;
        if (dout_b0 !== 32'h00000011) begin
            n_fail++;
            $display("FAIL bypass0_old: got %h expected 00000011", dout_b0);
        end
        n_checks++;
        if (dout_b1 !== 32'h00000055) begin
            n_fail++;
            $display("FAIL bypass1_new: got %h expected 00000055", dout_b1);
        end
        tick();
        ce_b_n = 1'b1;
        n_checks++;
        if (dout_b0 !== 32'h00000055 || dout_b1 !== 32'h00000055) begin
            n_fail++;
            $display("FAIL bypass_after: got %h/%h expected 00000055", dout_b0, dout_b1);
        end
    endtask

    task automatic test_clear();
        int cnt = 0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        while (busy0 && cnt < 400) begin
            cnt++;
            idle_inputs();
            if (cnt == 2) begin
                addr_a = 8'h10; ce_a_n = 4'b1011; addr_b = 8'h20; ce_b_n = 1'b0;
            end
            if (cnt == 5) begin
                addr_a = 8'h02; din_a = 8'h77; we_a_n = 4'b1110;
            end
            tick();
            if (cnt == 2) begin
                n_checks++;
                if (dout_a0 !== 8'h3C || dout_b0 !== 32'h00000055) begin
                    n_fail++;
                    $display("FAIL busy_hold: dout_a=%h dout_b=%h expected 3c 00000055",
                             dout_a0, dout_b0);
                end
            end
        end
        idle_inputs();
        n_checks++;
        if (cnt !== 256) begin
            n_fail++;
            $display("FAIL clr_len: busy cycles got %0d expected 256", cnt);
        end
        foreach (clr_tab[i]) begin
            read_b(clr_tab[i]);
            n_checks++;
            if (dout_b0 !== 32'h0) begin
                n_fail++;
                $display("FAIL cleared[%h]: got %h expected 00000000", clr_tab[i], dout_b0);
            end
        end
        addr_a = 8'h20; ce_a_n = 4'b0111;
        tick();
        ce_a_n = '1;
        n_checks++;
        if (dout_a0 !== 8'h00) begin
            n_fail++;
            $display("FAIL cleared_a: got %h expected 00", dout_a0);
        end
    endtask
    logic [7:0] clr_tab [4] = '{8'h02, 8'h10, 8'h20, 8'h40};

    task automatic test_back_to_back();
        addr_a = 8'h30; din_a = 8'h9A; we_a_n = 4'b1101;
        tick();
        din_a = 8'h12; we_a_n = 4'b1110;
        tick();
        we_a_n = '1;
        read_b(8'h30);
        n_checks++;
        if (dout_b0 !== 32'h00009A12) begin
            n_fail++;
            $display("FAIL back_to_back: got %h expected 00009a12", dout_b0);
        end
    endtask

    task automatic test_reset_mid_clear();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (busy0 !== 1'b1 || dout_b0 !== 32'h0 || dout_a0 !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_state: busy=%b dout_a=%h dout_b=%h expected 1 00 00000000",
                     busy0, dout_a0, dout_b0);
        end
        reset_n = 1'b1;
        count_busy("mid_reset_clear_len");
        read_b(8'h30);
        n_checks++;
        if (dout_b0 !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_cleared: got %h expected 00000000", dout_b0);
        end
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0; addr_a = '0; din_a = '0; addr_b = '0;
        @(negedge clk);
        test_reset();
        test_write_bank2();
        test_priority();
        test_bypass();
        test_clear();
        test_back_to_back();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pf_ram_banked.md
Name: pf_ram_banked

Overview:
- Parametrised, fully synchronous successor to the playfield dual-port RAM.
- NBANKS independent byte-lane banks share one address space.
- Port A is the CPU side: single-bank read/write, active-low selects, highest bank index wins.
- Port B is the video side: read-only, returns all banks in parallel.
- Adds registered read data, a configurable port-B write-bypass mode, and a hardware clear sequencer that zeroes the playfield after reset or on request.

Parameters:
- NBANKS, 4, number of banks/lanes; port B width = NBANKS*DW.
- AW, 8, address width; depth = 2**AW.
- DW, 8, data width per bank.
- CLEAR_ON_RESET, 1, 1 = clear sequencer starts automatically on reset release.
- B_BYPASS, 0, 1 = port B sees same-cycle port A write data; 0 = port B sees old data.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous reset, active low.
- addr_a  in  AW  port A address.
- din_a  in  DW  port A write data.
- dout_a  out  DW  port A read data, registered.
- ce_a_n  in  NBANKS  port A bank selects, active low.
- we_a_n  in  NBANKS  port A bank write enables, active low.
- addr_b  in  AW  port B address.
- ce_b_n  in  1  port B read enable, active low.
- dout_b  out  NBANKS*DW  port B read data {bank NBANKS-1 .. bank 0}, registered.
- clr_req  in  1  pulse high to start a clear from IDLE.
- busy  out  1  high while the clear sequencer owns the RAM.

Behaviour:
- Reset (reset_n=0 at an edge):
  - dout_a<=0, dout_b<=0, clear counter<=0.
  - State<=CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - busy is decoded from state, so it is 1 during reset when CLEAR_ON_RESET=1.
  - Reset mid-clear restarts the clear from address 0.
- Port A write:
  - Active when any we_a_n bit is 0 and state==IDLE.
  - Writes din_a to the single lowest-priority-encoded bank, i.e. the highest index with we_a_n=0.
  - Other enabled lanes are ignored: one bank per write.
  - The write is committed at the clock edge.
- Port A read:
  - Active when all we_a_n=1, any ce_a_n=0, and state==IDLE.
  - Reads the highest-index selected bank; dout_a is valid 1 cycle later.
  - Read-old on the same-address write of the previous cycle is not possible, since writes and reads are mutually exclusive on port A.
- No port A access (all ce_a_n=1 and all we_a_n=1): dout_a holds its previous value.
- Port B read:
  - Active when ce_b_n=0 and state==IDLE; all banks at addr_b are read and dout_b is valid 1 cycle later.
  - When ce_b_n=1, dout_b holds.
- Port B vs. same-cycle port A write to the same address:
  - B_BYPASS=0: the written lane in dout_b shows the old data.
  - B_BYPASS=1: the written lane shows din_a.
  - Other lanes are unaffected in both modes.
- State machine:
  - IDLE -> CLEAR when clr_req=1. clr_req is ignored while in CLEAR.
  - CLEAR: each cycle writes 0 to all banks at the counter address, then increments the counter.
  - CLEAR -> IDLE on the edge that writes address 2**AW-1; the counter wraps to 0.
  - A clear takes exactly 2**AW cycles; busy is high for exactly those cycles.
- While busy:
  - Port A writes are dropped, not queued.
  - Port A and port B reads are suppressed, so dout_a and dout_b hold.
- Memory contents are undefined after power-up if CLEAR_ON_RESET=0 and no clear is run.
- Widths: all indices are unsigned; there is no address wrap other than the natural AW-bit counter.

Test Plan:
- Reset with CLEAR_ON_RESET=1, AW=8: release reset_n -> busy=1 for exactly 256 cycles, then 0. Port B reads at 0x00, 0x7F and 0xFF then return 32'h0.
- Port A write addr_a=0x10, din_a=0xA5, we_a_n=4'b1011 -> bank2[0x10]=0xA5. Port B read of 0x10 the next cycle -> dout_b=32'h00A50000.
- we_a_n=4'b0110 with din_a=0x3C at 0x20 -> only bank3 written. Port A read at 0x20 with ce_a_n=4'b1110 -> dout_a=0x00; with ce_a_n=4'b0111 -> dout_a=0x3C.
- Same-cycle port A write of 0x55 to bank0 at 0x40 (old value 0x11) with port B reading 0x40:
  - B_BYPASS=0 -> low byte 0x11.
  - B_BYPASS=1 -> low byte 0x55.
- clr_req pulse, then a port A write at cycle 5 of the clear -> write dropped. After busy falls, all locations read 0.
- reset_n asserted at clear cycle 100, then released -> busy high for a full 256 cycles from the release, and the counter restarts at 0.
